mux_scan: RTL and testbench
===========================

MUX_SCAN -- requirements
Module: mux_scan

Interface
REQ-001 SHALL have parameter N, default 16, number of input channels (2..256).
REQ-002 SHALL have parameter W, default 1, data width per channel.
REQ-003 SHALL derive localparam SW = clog2(N), select/channel-index width.
REQ-004 SHALL have one clock and a synchronous, active-high reset: clk input 1, rising-edge clock; rst input 1, synchronous active-high reset.
REQ-005 SHALL have port `in` input N*W, channel k at bits [k*W +: W].
REQ-006 SHALL have port `sw` input SW, manual channel select.
REQ-007 SHALL have port `mode` input 1, 0 = manual, 1 = scan.
REQ-008 SHALL have port `start` input 1, scan start pulse.
REQ-009 SHALL have port `f_ready` input 1, downstream accepts f.
REQ-010 SHALL have port `f` output W, registered selected data.
REQ-011 SHALL have port `f_valid` output 1, f holds a beat.
REQ-012 SHALL have port `ch` output SW, channel index of current f.
REQ-013 SHALL have port `busy` output 1, scan in progress.
REQ-014 SHALL have port `done` output 1, one-cycle pulse at scan end.

Function
REQ-015 SHALL implement a one-entry output register; a beat is accepted in any cycle with f_valid=1 and f_ready=1.
REQ-016 SHALL load the output register only when it is empty or being accepted in the same cycle, so back-to-back beats run at full rate and f/ch stay stable while f_valid=1 and f_ready=0.
REQ-017 Manual mode (mode=0, FSM IDLE): SHALL load f=in[sw], ch=sw, f_valid=1 every load opportunity, with 1-cycle latency from sw/in to f.
REQ-018 SHALL output f=0 for any select value >= N (N not a power of 2), with ch and f_valid following normal rules.
REQ-019 SHALL implement FSM states IDLE, SCAN, DONE.
REQ-020 IDLE->SCAN SHALL occur on start=1 with mode=1; the scan counter is cleared to 0; start is ignored in SCAN and DONE.
REQ-021 SCAN SHALL load channel cnt into the output register at each load opportunity, then increment cnt.
REQ-022 SCAN->DONE SHALL occur when the beat for channel N-1 is accepted.
REQ-023 DONE SHALL assert done=1 for exactly one cycle, then return to IDLE.
REQ-024 busy SHALL be 1 in SCAN; f_valid SHALL drop in DONE unless a manual load occurs.
REQ-025 Changing mode to 0 during SCAN SHALL abort the scan: any held beat completes normally, the FSM goes to IDLE, and done is not asserted.
REQ-026 in SHALL be sampled at load time; in changing while a beat is held SHALL NOT alter f.
REQ-027 No beat SHALL be dropped or duplicated; a scan emits exactly N beats, with ch = 0..N-1 in order.

Reset
REQ-028 rst=1 at a clock edge SHALL force FSM=IDLE, cnt=0, f=0, ch=0, f_valid=0, busy=0, done=0.
REQ-029 Reset mid-scan SHALL discard the held beat and the remaining scan, and SHALL NOT produce a done pulse.
REQ-030 The first load after reset release SHALL occur on the first clock edge with rst=0.

Configuration
REQ-031 With macro MUX_SCAN_MASK_EN defined, SHALL add input `mask` of width N, sampled at scan start.
REQ-032 With the mask, SCAN SHALL skip channels whose mask bit is 0, emitting beats only for enabled channels in ascending order.
REQ-033 The last enabled channel SHALL end the scan.
REQ-034 An all-zero mask SHALL go IDLE->DONE directly, with no beats and done pulsed.
REQ-035 Without MUX_SCAN_MASK_EN, SHALL have no mask port and all N channels are scanned.

Verification
REQ-036 Manual sweep: N=16, W=1, f_ready=1, in=one-hot(k), sw=k for k=0..15 -> next cycle f=1, ch=k each step.
REQ-037 Backpressure: manual, f_ready=0 for 5 cycles while sw/in change -> f, ch, f_valid=1 frozen; the new value appears 1 cycle after f_ready=1.
REQ-038 Full scan: N=16, W=8, in[k]=k+8'h10, start pulse, f_ready toggling 1/0 -> exactly 16 accepted beats f=8'h10..8'h1F, then done=1 for 1 cycle, busy=0.
REQ-039 Reset mid-scan: rst=1 after the 5th accepted beat -> next cycle all outputs 0, no done; a new start rescans from ch=0.
REQ-040 Abort and non-power-of-2: N=5, mode->0 after 2 beats -> no done; sw=6 manual -> f=0.
REQ-041 Mask (MUX_SCAN_MASK_EN): mask=16'h8421 -> beats ch=0,5,10,15 then done; mask=0 -> done with no beats.

Source files
------------

// File: rtl/mux_scan.sv
// rtl/mux_scan.sv - N-channel mux with manual select and scan sequencer behind a one-entry output register
// Optional feature macro: MUX_SCAN_MASK_EN adds a per-channel scan enable mask sampled at scan start.
module mux_scan #(
  parameter int N = 16,
  parameter int W = 1,
  localparam int SW = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N*W-1:0] in,
  input  logic [SW-1:0]  sw,
  input  logic           mode,
  input  logic           start,
  input  logic           f_ready,
`ifdef MUX_SCAN_MASK_EN
  input  logic [N-1:0]   mask,
`endif
  output logic [W-1:0]   f,
  output logic           f_valid,
  output logic [SW-1:0]  ch,
  output logic           busy,
  output logic           done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SCAN = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [SW:0] N_LIM = (SW + 1)'(N);

  state_t          r_state;
  state_t          w_state_nxt;
  logic [N-1:0]    r_pend;
  logic [N-1:0]    w_pend_nxt;
  logic [W-1:0]    r_f;
  logic [SW-1:0]   r_ch;
  logic            r_f_valid;

  logic [W-1:0]    w_chan [N];
  logic [W-1:0]    w_man_data;
  logic [SW-1:0]   w_cnt;
  logic            w_load_ok;
  logic            w_acc;
  logic            w_load;
  logic [W-1:0]    w_ld_data;
  logic [SW-1:0]   w_ld_ch;

  for (genvar k = 0; k < N; k++) begin : g_chan
    assign w_chan[k] = in[k*W +: W];
  end

  // Out-of-range selects (only possible when N is not a power of two) read as zero.
  assign w_man_data = ({1'b0, sw} < N_LIM) ? w_chan[sw] : '0;

  assign w_load_ok = !r_f_valid || f_ready;
  assign w_acc     = r_f_valid && f_ready;

  // r_pend holds the channels still to be loaded in this scan; the next one is its lowest set bit.
  always_comb begin
    w_cnt = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (r_pend[k]) w_cnt = SW'(k);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pend_nxt  = r_pend;
    w_load      = 1'b0;
    w_ld_data   = w_man_data;
    w_ld_ch     = sw;
    case (r_state)
      S_IDLE: begin
        if (!mode) begin
          w_load = w_load_ok;
        end else if (start) begin
`ifdef MUX_SCAN_MASK_EN
          w_pend_nxt  = mask;
          w_state_nxt = (mask == '0) ? S_DONE : S_SCAN;
`else
          w_pend_nxt  = '1;
          w_state_nxt = S_SCAN;
`endif
        end
      end
      S_SCAN: begin
        if (!mode) begin
          w_state_nxt = S_IDLE;
          w_pend_nxt  = '0;
        end else begin
          if (w_load_ok && (r_pend != '0)) begin
            w_load             = 1'b1;
            w_ld_data          = w_chan[w_cnt];
            w_ld_ch            = w_cnt;
            w_pend_nxt[w_cnt]  = 1'b0;
          end
          // With nothing left pending, the held beat is the last scan beat.
          if (w_acc && (r_pend == '0)) w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
        w_load      = !mode && w_load_ok;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_pend    <= '0;
      r_f       <= '0;
      r_ch      <= '0;
      r_f_valid <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_pend  <= w_pend_nxt;
      if (w_load) begin
        r_f       <= w_ld_data;
        r_ch      <= w_ld_ch;
        r_f_valid <= 1'b1;
      end else if (w_acc) begin
        r_f_valid <= 1'b0;
      end
    end
  end

  assign f       = r_f;
  assign ch      = r_ch;
  assign f_valid = r_f_valid;
  assign busy    = (r_state == S_SCAN);
  assign done    = (r_state == S_DONE);

endmodule

// File: tb/tb_mux_scan.sv
// tb/tb_mux_scan.sv - self-checking bench for mux_scan (N=16/W=8 and N=5/W=4 instances)
// Covers the MUX_SCAN_MASK_EN build when that macro is defined.
module tb_mux_scan;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Instance A: N=16, W=8
  logic [127:0] a_in;
  logic [3:0]   a_sw;
  logic         a_rst, a_mode, a_start, a_f_ready;
  logic [15:0]  a_mask;
  logic [7:0]   a_f;
  logic         a_f_valid, a_busy, a_done;
  logic [3:0]   a_ch;
  logic [7:0]   a_val [16];

  // Instance B: N=5, W=4
  logic [19:0]  b_in;
  logic [2:0]   b_sw;
  logic         b_rst, b_mode, b_start, b_f_ready;
  logic [4:0]   b_mask;
  logic [3:0]   b_f;
  logic         b_f_valid, b_busy, b_done;
  logic [2:0]   b_ch;
  logic [3:0]   b_val [5];

  mux_scan #(.N(16), .W(8)) u_dut_a (
    .clk(clk), .rst(a_rst), .in(a_in), .sw(a_sw), .mode(a_mode), .start(a_start),
    .f_ready(a_f_ready),
`ifdef MUX_SCAN_MASK_EN
    .mask(a_mask),
`endif
    .f(a_f), .f_valid(a_f_valid), .ch(a_ch), .busy(a_busy), .done(a_done)
  );

  mux_scan #(.N(5), .W(4)) u_dut_b (
    .clk(clk), .rst(b_rst), .in(b_in), .sw(b_sw), .mode(b_mode), .start(b_start),
    .f_ready(b_f_ready),
`ifdef MUX_SCAN_MASK_EN
    .mask(b_mask),
`endif
    .f(b_f), .f_valid(b_f_valid), .ch(b_ch), .busy(b_busy), .done(b_done)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pack_a();
    for (int k = 0; k < 16; k++) a_in[k*8 +: 8] = a_val[k];
  endtask

  task automatic pack_b();
    for (int k = 0; k < 5; k++) b_in[k*4 +: 4] = b_val[k];
  endtask

  // Expected scan order comes from the mask (all channels when the mask feature is absent).
  task automatic run_scan_a(input int rst_after, input bit rnd_ready);
    int         exp_ch[$];
    int         got_ch[$];
    int         got_f[$];
    logic [7:0] snap [16];
    int         dn;
    int         busy_bad;
    int         dseen;
    bit         did_rst;
    dn = 0; busy_bad = 0; dseen = 0; did_rst = 1'b0;
    for (int k = 0; k < 16; k++) begin
`ifdef MUX_SCAN_MASK_EN
      if (a_mask[k]) exp_ch.push_back(k);
`else
      exp_ch.push_back(k);
`endif
      snap[k] = a_val[k];
    end
    a_mode = 1'b1; a_f_ready = 1'b1;
    step();
    a_start = 1'b1;
    step();
    a_start = 1'b0;
    for (int c = 0; c < 200; c++) begin
      if (a_done) begin
        dn++;
        break;
      end
      if (a_busy !== 1'b1) busy_bad++;
      if (rst_after > 0 && got_ch.size() == rst_after) begin
        a_rst = 1'b1;
        step();
        a_rst = 1'b0;
        did_rst = 1'b1;
        break;
      end
      a_f_ready = rnd_ready ? 1'($urandom_range(0, 1)) : ((c % 2) == 0);
      if (a_f_valid && a_f_ready) begin
        got_ch.push_back(int'(a_ch));
        got_f.push_back(int'(a_f));
      end
      step();
    end
    chk("scan_busy", busy_bad, 0);
    if (did_rst) begin
      chk("rst_f", a_f, 0);
      chk("rst_ch", a_ch, 0);
      chk("rst_f_valid", a_f_valid, 0);
      chk("rst_busy", a_busy, 0);
      chk("rst_done", a_done, 0);
      repeat (4) begin
        step();
        if (a_done) dseen++;
      end
      chk("rst_no_done", dseen, 0);
      chk("rst_beats", got_ch.size(), rst_after);
    end else begin
      chk("scan_done_seen", dn, 1);
      chk("scan_beats", got_ch.size(), exp_ch.size());
      for (int i = 0; i < exp_ch.size() && i < got_ch.size(); i++) begin
        chk("scan_ch", got_ch[i], exp_ch[i]);
        chk("scan_f", got_f[i], int'(snap[exp_ch[i]]));
      end
      step();
      chk("done_one_cycle", a_done, 0);
      chk("busy_after", a_busy, 0);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] hold_f;
    int         s0;
    int         s1;
    int         bgot[$];
    int         dseen;
    a_rst = 1'b1; a_mode = 1'b0; a_start = 1'b0; a_f_ready = 1'b1; a_sw = '0; a_mask = '1;
    b_rst = 1'b1; b_mode = 1'b0; b_start = 1'b0; b_f_ready = 1'b1; b_sw = '0; b_mask = '1;
    for (int k = 0; k < 16; k++) a_val[k] = 8'($urandom);
    for (int k = 0; k < 5; k++) b_val[k] = 4'($urandom);
    pack_a(); pack_b();
    step(); step();
    chk("reset_f", a_f, 0);
    chk("reset_ch", a_ch, 0);
    chk("reset_f_valid", a_f_valid, 0);
    chk("reset_busy", a_busy, 0);
    chk("reset_done", a_done, 0);
    chk("reset_b_f_valid", b_f_valid, 0);

    // First edge with rst low loads immediately.
    a_sw = 4'd3; a_rst = 1'b0; b_rst = 1'b0;
    step();
    chk("first_load_f", a_f, a_val[3]);
    chk("first_load_ch", a_ch, 3);
    chk("first_load_valid", a_f_valid, 1);

    for (int k = 0; k < 16; k++) begin
      for (int j = 0; j < 16; j++) a_val[j] = 8'(j == k);
      pack_a();
      a_sw = 4'(k);
      step();
      chk("sweep_f", a_f, 1);
      chk("sweep_ch", a_ch, k);
    end

    for (int i = 0; i < 20; i++) begin
      for (int j = 0; j < 16; j++) a_val[j] = 8'($urandom);
      pack_a();
      s0 = int'($urandom_range(0, 15));
      a_sw = 4'(s0);
      step();
      chk("rand_manual_f", a_f, a_val[s0]);
      chk("rand_manual_ch", a_ch, s0);
    end

    // Backpressure: held beat must not move while f_ready is low.
    s0 = int'($urandom_range(0, 15));
    a_sw = 4'(s0);
    step();
    hold_f = a_val[s0];
    a_f_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      for (int j = 0; j < 16; j++) a_val[j] = 8'($urandom);
      pack_a();
      a_sw = 4'($urandom_range(0, 15));
      step();
      chk("bp_f", a_f, hold_f);
      chk("bp_ch", a_ch, s0);
      chk("bp_valid", a_f_valid, 1);
    end
    s1 = (s0 + 7) % 16;
    a_sw = 4'(s1);
    a_f_ready = 1'b1;
    step();
    chk("bp_release_f", a_f, a_val[s1]);
    chk("bp_release_ch", a_ch, s1);

    for (int k = 0; k < 16; k++) a_val[k] = 8'(k + 8'h10);
    pack_a();
    run_scan_a(0, 1'b0);

    for (int k = 0; k < 16; k++) a_val[k] = 8'($urandom);
    pack_a();
    run_scan_a(0, 1'b1);
    run_scan_a(5, 1'b1);
    run_scan_a(0, 1'b1);

`ifdef MUX_SCAN_MASK_EN
    a_mask = 16'h8421;
    run_scan_a(0, 1'b1);
    a_mask = 16'h0000;
    run_scan_a(0, 1'b1);
    a_mask = 16'hFFFF;
`endif

    // Instance B: abort after two beats, then out-of-range manual select.
    b_mode = 1'b1; b_f_ready = 1'b1;
    step();
    b_start = 1'b1;
    step();
    b_start = 1'b0;
    for (int c = 0; c < 50; c++) begin
      if (bgot.size() == 2) break;
      if (b_f_valid && b_f_ready) bgot.push_back(int'(b_ch));
      step();
    end
    chk("abort_beats", bgot.size(), 2);
    chk("abort_held_ch", b_ch, 2);
    chk("abort_held_f", b_f, b_val[2]);
    chk("abort_held_valid", b_f_valid, 1);
    if (bgot.size() == 2) begin
      chk("abort_ch0", bgot[0], 0);
      chk("abort_ch1", bgot[1], 1);
    end
    b_mode = 1'b0;
    b_sw = 3'd1;
    dseen = 0;
    repeat (6) begin
      step();
      if (b_done) dseen++;
    end
    chk("abort_no_done", dseen, 0);
    chk("abort_busy", b_busy, 0);
    chk("abort_manual_f", b_f, b_val[1]);

    b_sw = 3'd6;
    step();
    chk("oor6_f", b_f, 0);
    chk("oor6_ch", b_ch, 6);
    chk("oor6_valid", b_f_valid, 1);
    b_sw = 3'd4;
    step();
    chk("last_ch_f", b_f, b_val[4]);
    b_sw = 3'd5;
    step();
    chk("oor5_f", b_f, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
